// File: rtl/downcounter_timer_if.sv
// Handshake bundle for downcounter_timer: load/value/enable in, count and status out.
// The master side drives the controls; the timer itself is the slave.
interface downcounter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] a;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output load, a, en,
    input  count, tc, zero, busy, done
  );

  modport slave (
    input  load, a, en,
    output count, tc, zero, busy, done
  );
endinterface

// File: rtl/downcounter_timer.sv
// Loadable down-counting interval timer with a one-cycle terminal-count pulse.
// Define DOWNCOUNTER_TIMER_AUTORELOAD_EN for periodic reload instead of one-shot stop.
module downcounter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  downcounter_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // Load beats any expiry on the same edge, so tc only pulses from an unloaded RUN edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      count_d = bus.a;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
      reload_d = bus.a;
`endif
      state_d = (bus.a != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (bus.en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
              count_d = reload_q;
              state_d = RUN;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end
          end
        end
        DONE: count_d = '0;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.zero  = (count_q == '0);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);

endmodule

// File: doc/downcounter_timer.md
# downcounter_timer

Loadable down-counting interval timer, the counterpart to the team's loadable up counter. It counts a loaded value down to zero on enabled cycles, flags expiry with a one-cycle terminal-count pulse, and then either stops (one-shot) or reloads (auto-reload build). It sits beside the up counter in the sequential-circuit library and serves as the timeout/interval generator for control FSMs.

## Interface
Parameters:
- WIDTH, 4, counter and load-value width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- load  input  1  capture `a` into count and reload register
- a  input  WIDTH  load value, unsigned
- en  input  1  count enable; decrements only when high in RUN
- count  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle per expiry
- zero  output  1  high when count == 0
- busy  output  1  high in RUN
- done  output  1  high in DONE

## Operation
- State machine (registered), transitions on rising clk edge:
  - IDLE: after reset, or after load with a == 0. Stays in IDLE; `en` is ignored.
  - RUN: entered on load with a != 0.
    - en=1, count>1: count ← count−1.
    - en=1, count==1: expiry; count ← 0, tc ← 1, next state DONE (one-shot).
    - en=0: hold count.
  - DONE: count stays 0; `en` ignored; leaves only on load or rst.
- Priority per edge: rst > load > count/expiry.
- load in any state: count ← a, reload ← a, tc ← 0; next state RUN if a != 0, else IDLE.
- No underflow: count never decrements below 0, and never wraps to 2^WIDTH−1.
- Arithmetic is unsigned, WIDTH bits. Maximum interval is 2^WIDTH−1 enabled cycles.
- Combinational outputs:
  - zero = (count == 0)
  - busy = (state == RUN)
  - done = (state == DONE)

## Timing
- Reset values after an edge with rst=1: count=0, reload=0, state IDLE, tc=0, busy=0, done=0, zero=1.
- Load latency is one edge: with load=1 at edge k, count == a after edge k.
- tc latency: for load value N, tc is high in the cycle after the N-th enabled edge following the load edge. That is the same cycle in which count first shows 0 (one-shot) or shows the reload value (auto-reload).
- tc is high for exactly one cycle; it clears on the next edge regardless of `en`.
- Load coinciding with expiry (count==1, en=1, load=1): load wins; count ← a, tc stays 0, no expiry is recorded.
- rst mid-RUN: all outputs take their reset values on that edge; any pending expiry is discarded.
- en toggling in RUN: only edges with en=1 are counted; no minimum gap between enables.

## Configuration
- Macro: DOWNCOUNTER_TIMER_AUTORELOAD_EN.
- Defined: expiry in RUN sets count ← reload, pulses tc, and stays in RUN, giving a periodic tc every N enabled cycles. DONE is unreachable and done stays 0. load with a == 0 still goes to IDLE.
- Undefined: one-shot behaviour as described in Operation. The reload register may be optimized away.

## Test plan
- WIDTH=4, rst, then load a=3 with en=1 held → count sequence 3,2,1,0; tc=1 only in the cycle count=0; busy falls and done rises on that same edge; count stays 0 afterwards.
- load a=5, en pattern 1,0,1,1,0,0,1,1 → count 5,4,4,3,2,2,2,1,0; tc pulses once, at count=0.
- load a=0 → state IDLE, count=0, zero=1, busy=0, tc never asserts; en=1 for 10 cycles leaves count at 0 (no wrap to 15).
- Reach count==1 with en=1 and load=1, a=9 on the same edge → count=9, tc=0, busy=1; later expiry after 9 enabled edges.
- In RUN at count=2, assert rst for one edge with load=1, en=1 → count=0, tc=0, busy=0, done=0, zero=1.
- With DOWNCOUNTER_TIMER_AUTORELOAD_EN: load a=2, en=1 held → count 2,1,2,1,…; tc high in every cycle count returns to 2; done never asserts.
